// File: rtl/fusion_issue_if.sv
// Pair-in / entry-out handshake bundle between fusion scan/decode and the issue stage.
// The slave modport is the sequencer's view of the bundle.
interface fusion_issue_if #(
    parameter type entry_t = logic
);
    entry_t     pair [2];
    logic [1:0] pair_valid;
    logic       pair_fused;
    logic       pair_ready;
    entry_t     issue;
    logic       issue_valid;
    logic       issue_ready;
    logic       issue_fused;

    modport master (
        output pair, pair_valid, pair_fused, issue_ready,
        input  pair_ready, issue, issue_valid, issue_fused
    );

    modport slave (
        input  pair, pair_valid, pair_fused, issue_ready,
        output pair_ready, issue, issue_valid, issue_fused
    );
endinterface

// File: rtl/fusion_issue_seq.sv
// Buffers one decoded pair and issues it slot by slot, dropping the absorbed slot 0 of a
// fused pair when fusion is enabled; counts issued fused entries with saturation.
module fusion_issue_seq #(
    parameter type         entry_t = logic,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             fusion_en_i,
    fusion_issue_if.slave    bus,
    output logic [CNT_W-1:0] fused_cnt_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {EMPTY, SLOT0, SLOT1} state_e;

    state_e           state_q;
    entry_t           buf1_q;
    entry_t           issue_q;
    logic             v1_q;
    logic             fused_q;
    logic             valid_q;
    logic             issue_fused_q;
    logic [CNT_W-1:0] cnt_q;

    logic       fuse_take;
    logic [1:0] v_cap;
    logic       hs;
    logic       accept;

    // A fused flag on an incomplete pair is ignored: both slots must be present to fuse.
    always_comb begin
        fuse_take = bus.pair_fused && fusion_en_i && (bus.pair_valid == 2'b11);
        v_cap     = fuse_take ? 2'b10 : bus.pair_valid;
    end

    assign bus.issue       = issue_q;
    assign bus.issue_fused = issue_fused_q;
    assign bus.issue_valid = valid_q && !flush_i;
    assign hs              = bus.issue_valid && bus.issue_ready;

    // A new pair may enter only when the buffer is empty or its last slot leaves this cycle.
    assign bus.pair_ready = rst_ni && !flush_i &&
                            ((state_q == EMPTY) ||
                             ((state_q == SLOT1) && hs) ||
                             ((state_q == SLOT0) && hs && !v1_q));
    assign accept         = bus.pair_ready && (|bus.pair_valid);

    assign fused_cnt_o = cnt_q;
    assign busy_o      = (state_q != EMPTY);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values regardless of statement order inside this block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= EMPTY;
            buf1_q        <= '0;
            issue_q       <= '0;
            v1_q          <= 1'b0;
            fused_q       <= 1'b0;
            valid_q       <= 1'b0;
            issue_fused_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            if (hs && issue_fused_q && (cnt_q != '1))
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

            if (flush_i) begin
                state_q       <= EMPTY;
                v1_q          <= 1'b0;
                fused_q       <= 1'b0;
                valid_q       <= 1'b0;
                issue_fused_q <= 1'b0;
            end else if (accept) begin
                buf1_q  <= bus.pair[1];
                v1_q    <= v_cap[1];
                fused_q <= fuse_take;
                valid_q <= 1'b1;
                if (v_cap[0]) begin
                    state_q       <= SLOT0;
                    issue_q       <= bus.pair[0];
                    issue_fused_q <= 1'b0;
                end else begin
                    state_q       <= SLOT1;
                    issue_q       <= bus.pair[1];
                    issue_fused_q <= fuse_take;
                end
            end else if (hs) begin
                if ((state_q == SLOT0) && v1_q) begin
                    state_q       <= SLOT1;
                    issue_q       <= buf1_q;
                    issue_fused_q <= fused_q;
                end else begin
                    state_q       <= EMPTY;
                    v1_q          <= 1'b0;
                    fused_q       <= 1'b0;
                    valid_q       <= 1'b0;
                    issue_fused_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fusion_issue_seq.sv
// Directed bench for fusion_issue_seq: a vector table for the main flows plus hand-written
// stall, flush, saturation and mid-operation reset sequences.
module tb_fusion_issue_seq;
    typedef logic [7:0] entry_t;
    localparam int unsigned CNT_W = 2;

    typedef struct {
        logic             fl;
        logic             en;
        logic [1:0]       pv;
        logic             fu;
        logic             rdy;
        entry_t           p0;
        entry_t           p1;
        logic             ivld;
        entry_t           iss;
        logic             ifu;
        logic             prdy;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             fusion_en_i;
    logic [CNT_W-1:0] fused_cnt_o;
    logic             busy_o;

    int errors = 0;
    int checks = 0;

    fusion_issue_if #(.entry_t(entry_t)) bus ();

    fusion_issue_seq #(.entry_t(entry_t), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fusion_en_i (fusion_en_i),
        .bus         (bus.slave),
        .fused_cnt_o (fused_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic en, input logic [1:0] pv, input logic fu,
                         input logic rdy, input entry_t p0, input entry_t p1);
        flush_i         = fl;
        fusion_en_i     = en;
        bus.pair_valid  = pv;
        bus.pair_fused  = fu;
        bus.issue_ready = rdy;
        bus.pair[0]     = p0;
        bus.pair[1]     = p1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b1, 2'b00, 1'b0, rdy, 8'h00, 8'h00);
    endtask

    task automatic expect_out(input string tag, input logic ivld, input entry_t iss,
                              input logic ifu, input logic prdy, input logic busy,
                              input logic [CNT_W-1:0] cnt);
        check({tag, " issue_valid"}, 32'(bus.issue_valid), 32'(ivld));
        if (ivld) begin
            check({tag, " issue"}, 32'(bus.issue), 32'(iss));
            check({tag, " issue_fused"}, 32'(bus.issue_fused), 32'(ifu));
        end
        check({tag, " pair_ready"}, 32'(bus.pair_ready), 32'(prdy));
        check({tag, " busy"}, 32'(busy_o), 32'(busy));
        check({tag, " fused_cnt"}, 32'(fused_cnt_o), 32'(cnt));
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    vec_t vecs [16];
    logic [CNT_W-1:0] mcnt;

    initial begin
        //          fl  en  pv     fu  rdy  p0     p1      ivld iss    ifu prdy busy cnt
        vecs[0]  = '{0, 1, 2'b11, 0, 1, 8'hA1, 8'hA2,  0, 8'h00, 0, 1, 0, 2'd0}; // unfused accept
        vecs[1]  = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'hA1, 0, 0, 1, 2'd0};
        vecs[2]  = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'hA2, 0, 1, 1, 2'd0};
        vecs[3]  = '{0, 1, 2'b11, 1, 1, 8'hB1, 8'hB2,  0, 8'h00, 0, 1, 0, 2'd0}; // fused, en=1
        vecs[4]  = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'hB2, 1, 1, 1, 2'd0};
        vecs[5]  = '{0, 0, 2'b11, 1, 1, 8'hC1, 8'hC2,  0, 8'h00, 0, 1, 0, 2'd1}; // fused, en=0
        vecs[6]  = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'hC1, 0, 0, 1, 2'd1}; // en flips mid-pair
        vecs[7]  = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'hC2, 0, 1, 1, 2'd1};
        vecs[8]  = '{0, 1, 2'b11, 0, 1, 8'hD1, 8'hD2,  0, 8'h00, 0, 1, 0, 2'd1}; // back-to-back
        vecs[9]  = '{0, 1, 2'b01, 0, 1, 8'hE1, 8'hE2,  1, 8'hD1, 0, 0, 1, 2'd1};
        vecs[10] = '{0, 1, 2'b01, 0, 1, 8'hE1, 8'hE2,  1, 8'hD2, 0, 1, 1, 2'd1};
        vecs[11] = '{0, 1, 2'b11, 1, 1, 8'hF1, 8'hF2,  1, 8'hE1, 0, 1, 1, 2'd1};
        vecs[12] = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'hF2, 1, 1, 1, 2'd1};
        vecs[13] = '{0, 1, 2'b10, 1, 1, 8'h71, 8'h72,  0, 8'h00, 0, 1, 0, 2'd2}; // fused, incomplete
        vecs[14] = '{0, 1, 2'b00, 0, 1, 8'h00, 8'h00,  1, 8'h72, 0, 1, 1, 2'd2};
        vecs[15] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h00,  0, 8'h00, 0, 1, 0, 2'd2};

        rst_ni = 1'b0;
        idle(1'b0);
        #1;
        check("reset issue_valid", 32'(bus.issue_valid), 32'd0);
        check("reset issue_fused", 32'(bus.issue_fused), 32'd0);
        check("reset pair_ready", 32'(bus.pair_ready), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset fused_cnt", 32'(fused_cnt_o), 32'd0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        #1;
        expect_out("post-reset", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].fl, vecs[i].en, vecs[i].pv, vecs[i].fu, vecs[i].rdy,
                  vecs[i].p0, vecs[i].p1);
            #1;
            expect_out($sformatf("vec%0d", i), vecs[i].ivld, vecs[i].iss, vecs[i].ifu,
                       vecs[i].prdy, vecs[i].busy, vecs[i].cnt);
            next_cycle();
        end

        // Stall in SLOT0 for 5 cycles while a new pair is offered.
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 8'h82);
        #1;
        expect_out("stall accept", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h91, 8'h92);
            #1;
            expect_out($sformatf("stall%0d", k), 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 2'd2);
            next_cycle();
        end
        idle(1'b1);
        #1;
        expect_out("stall release0", 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 2'd2);
        next_cycle();
        idle(1'b1);
        #1;
        expect_out("stall release1", 1'b1, 8'h82, 1'b0, 1'b1, 1'b1, 2'd2);
        next_cycle();

        // Flush in SLOT1 of a fused pair, with ready high and a new pair offered.
        drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 8'hA5, 8'hA6);
        #1;
        expect_out("flush accept", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2);
        next_cycle();
        idle(1'b0);
        #1;
        expect_out("flush slot1", 1'b1, 8'hA6, 1'b1, 1'b0, 1'b1, 2'd2);
        next_cycle();
        drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'hB5, 8'hB6);
        #1;
        check("flush issue_valid", 32'(bus.issue_valid), 32'd0);
        check("flush pair_ready", 32'(bus.pair_ready), 32'd0);
        next_cycle();
        idle(1'b1);
        #1;
        expect_out("after flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2);
        next_cycle();

        // Back-to-back fused pairs drive the 2-bit counter into saturation.
        mcnt = 2'd2;
        drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 8'h4F, 8'h50);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 8'h40, entry_t'(8'h51 + k));
            else       idle(1'b1);
            #1;
            expect_out($sformatf("sat%0d", k), 1'b1, entry_t'(8'h50 + k), 1'b1, 1'b1, 1'b1, mcnt);
            next_cycle();
            if (mcnt != 2'd3) mcnt = mcnt + 2'd1;
        end
        idle(1'b1);
        #1;
        expect_out("sat final", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd3);

        // Slot-0-only pair issues once.
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'hC7, 8'hC8);
        next_cycle();
        idle(1'b1);
        #1;
        expect_out("v01 issue", 1'b1, 8'hC7, 1'b0, 1'b1, 1'b1, 2'd3);
        next_cycle();
        #1;
        expect_out("v01 done", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd3);

        // Asynchronous reset in the middle of a pair.
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hD7, 8'hD8);
        next_cycle();
        #1;
        check("pre-reset busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("midreset issue_valid", 32'(bus.issue_valid), 32'd0);
        check("midreset issue", 32'(bus.issue), 32'd0);
        check("midreset busy", 32'(busy_o), 32'd0);
        check("midreset fused_cnt", 32'(fused_cnt_o), 32'd0);
        check("midreset pair_ready", 32'(bus.pair_ready), 32'd0);
        next_cycle();
        rst_ni = 1'b1;
        idle(1'b1);
        #1;
        expect_out("after midreset", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
